shiftreg_tx_ctrl: RTL and testbench
===================================

Name: shiftreg_tx_ctrl

Overview:
Sequencer that sits directly upstream of the 8-bit universal shift register and drives its mode/sin/pin inputs. It accepts a word over a valid/ready handshake, issues one parallel-load cycle, then WIDTH shift cycles in the selected direction, then a done strobe. While shifting it asserts a qualifier so that downstream logic can sample the shift register's serial output.

Parameters:
WIDTH, 8, word length; equals the shift register width; shift counter is $clog2(WIDTH+1) bits
FILL, 1'b0, value driven on sin during shift cycles

Ports:
clk  input  1  rising-edge clock, shared with the shift register
rst  input  1  asynchronous, active-high reset
tx_data  input  WIDTH  word to transmit; sampled on handshake
tx_valid  input  1  upstream has a word
tx_ready  output  1  controller can accept a word; high only in IDLE
tx_dir  input  1  sampled on handshake; 0 = left shift (MSB first, mode 01), 1 = right shift (LSB first, mode 10)
abort  input  1  synchronous abort of the current word
mode  output  2  to shift register: 00 hold, 01 left, 10 right, 11 load
pin  output  WIDTH  to shift register parallel input
sin  output  1  to shift register serial input
sout_vld  output  1  high in each shift cycle; the shift register's sout is valid in that cycle
busy  output  1  high in LOAD, SHIFT and DONE
done  output  1  one-cycle pulse in DONE
bit_cnt  output  $clog2(WIDTH+1)  shifts completed in the current word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state and outputs are registered.
- Reset values: state=IDLE, mode=00, pin=0, sin=0, sout_vld=0, busy=0, done=0, bit_cnt=0, tx_ready=1, direction register=0.
- IDLE: mode=00, tx_ready=1.
  - On a clock edge with tx_valid && tx_ready, capture tx_data into pin and tx_dir into the direction register, then go to LOAD.
- LOAD (1 cycle): mode=11, pin=captured word, busy=1, tx_ready=0.
  - The shift register loads on the edge that ends this cycle.
  - Next state is SHIFT with bit_cnt=0.
- SHIFT (exactly WIDTH cycles): mode=01 if dir=0, 10 if dir=1; sin=FILL; sout_vld=1.
  - bit_cnt increments on each edge.
  - Left shift: during shift k the serial output is word bit WIDTH-1-k. Right shift: it is word bit k.
  - After the edge that makes bit_cnt==WIDTH, go to DONE.
- DONE (1 cycle): mode=00, done=1, sout_vld=0, busy=1, bit_cnt holds WIDTH. Next state is IDLE.
- Handshake:
  - Throughput is one word per WIDTH+3 cycles, measured handshake to handshake at best case.
  - tx_data and tx_dir may change freely after the accept edge.
  - tx_valid has no effect outside IDLE.
- abort:
  - Sampled in LOAD, SHIFT or DONE. The next cycle is IDLE with mode=00, sout_vld=0, bit_cnt=0, and no done pulse.
  - Ignored in IDLE.
  - If abort and tx_valid are both high in IDLE, the word is accepted normally.
- pin is held after LOAD until the next accept. It does not matter to the shift register outside LOAD.
- Reset asserted mid-word: all outputs return to their reset values immediately (asynchronous); no done pulse.
- The mode 11 and shift modes never overlap. mode is never 01 or 10 outside SHIFT.

Optional Feature:
SHIFTREG_TX_PARITY_EN.
- Defined: a registered output parity (1 bit) equal to the even parity (XOR) of the captured word, updated on accept. Output par_vld is high in DONE only. FILL is unaffected.
- Undefined: ports parity and par_vld are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then tx_data=8'hC1, tx_dir=0, one-cycle tx_valid -> next cycle mode=11 and pin=C1. Then 8 cycles of mode=01 with sout_vld=1 and shift-register sout=1,1,0,0,0,0,0,1. Then done=1 for one cycle, then tx_ready=1.
2. tx_data=8'hC1, tx_dir=1 -> 8 cycles of mode=10 with sout=1,0,0,0,0,0,1,1. Register holds 8'h00 after DONE (FILL=0).
3. tx_valid held high with 8'hA5 then 8'h3C -> accepts exactly 11 cycles apart. tx_ready is low throughout LOAD/SHIFT/DONE; the second word is not taken early.
4. abort asserted in shift cycle 3 of 8'hFF -> next cycle mode=00, sout_vld=0, bit_cnt=0, no done pulse, tx_ready=1.
5. rst pulsed in shift cycle 5 (asynchronously, between edges) -> outputs immediately reach their reset values. A following word 8'h81 transmits correctly.
6. With SHIFTREG_TX_PARITY_EN: 8'h07 -> parity=1 with par_vld in DONE. 8'h03 -> parity=0.

Source files
------------

// File: rtl/shiftreg_tx_ctrl.sv
// shiftreg_tx_ctrl: sequencer feeding an 8-bit universal shift register
//
// Accepts a word over tx_valid/tx_ready, drives one parallel-load cycle
// (mode 11), WIDTH shift cycles (mode 01 left / 10 right) and a one-cycle
// done strobe. abort returns to IDLE on the next edge without a done pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tx_data, tx_dir     word and direction (0 = MSB first, 1 = LSB first)
//   tx_valid, tx_ready  accept handshake; tx_ready high only in IDLE
//   abort               drop the current word (ignored in IDLE)
//   mode, pin, sin      shift register controls
//   sout_vld            shift register sout is valid this cycle
//   busy, done          word in flight / end-of-word pulse
//   bit_cnt             shifts completed in the current word
//   parity, par_vld     XOR of the captured word, flagged in DONE
//                       (present only with SHIFTREG_TX_PARITY_EN defined)
module shiftreg_tx_ctrl #(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic                       tx_dir,
    input  logic                       abort,
    output logic [1:0]                 mode,
    output logic [WIDTH-1:0]           pin,
    output logic                       sin,
    output logic                       sout_vld,
    output logic                       busy,
    output logic                       done,
`ifdef SHIFTREG_TX_PARITY_EN
    output logic                       parity,
    output logic                       par_vld,
`endif
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state, nxt;
    logic [CW-1:0] nxt_cnt;
    logic          dir, nxt_dir, accept;
    logic [1:0]    nxt_mode;

    assign accept = (state == IDLE) && tx_valid;

    always_comb begin
        nxt     = state;
        nxt_cnt = '0;
        case (state)
            IDLE:  nxt = tx_valid ? LOAD : IDLE;
            LOAD:  nxt = abort ? IDLE : SHIFT;
            SHIFT: begin
                nxt_cnt = abort ? '0 : bit_cnt + 1'b1;
                nxt     = abort ? IDLE : (nxt_cnt == CW'(WIDTH)) ? DONE : SHIFT;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they belong to without a combinational path out.
    always_comb begin
        nxt_dir  = accept ? tx_dir : dir;
        nxt_mode = (nxt == LOAD)  ? 2'b11 :
                   (nxt == SHIFT) ? (nxt_dir ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            dir      <= 1'b0;
            pin      <= '0;
            mode     <= 2'b00;
            sin      <= 1'b0;
            sout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b1;
`ifdef SHIFTREG_TX_PARITY_EN
            parity   <= 1'b0;
            par_vld  <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            bit_cnt  <= nxt_cnt;
            dir      <= nxt_dir;
            if (accept) pin <= tx_data;
            mode     <= nxt_mode;
            sin      <= (nxt == SHIFT) ? FILL : 1'b0;
            sout_vld <= (nxt == SHIFT);
            busy     <= (nxt != IDLE);
            done     <= (nxt == DONE);
            tx_ready <= (nxt == IDLE);
`ifdef SHIFTREG_TX_PARITY_EN
            if (accept) parity <= ^tx_data;
            par_vld  <= (nxt == DONE);
`endif
        end
    end
endmodule

// File: tb/tb_shiftreg_tx_ctrl.sv
// tb_shiftreg_tx_ctrl: vector table, corner sequences and random words for shiftreg_tx_ctrl
module tb_shiftreg_tx_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready, tx_dir, abort;
    logic [1:0]   mode;
    logic [W-1:0] pin;
    logic         sin, sout_vld, busy, done;
    logic [3:0]   bit_cnt;
`ifdef SHIFTREG_TX_PARITY_EN
    logic         parity, par_vld;
`endif

    int checks = 0;
    int errors = 0;

    shiftreg_tx_ctrl #(.WIDTH(W), .FILL(1'b0)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_dir(tx_dir), .abort(abort), .mode(mode),
        .pin(pin), .sin(sin), .sout_vld(sout_vld), .busy(busy), .done(done),
`ifdef SHIFTREG_TX_PARITY_EN
        .parity(parity), .par_vld(par_vld),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Universal shift register the controller drives
    logic [W-1:0] sr;
    logic         sout;
    always_ff @(posedge clk)
        case (mode)
            2'b11:   sr <= pin;
            2'b01:   sr <= {sr[W-2:0], sin};
            2'b10:   sr <= {sin, sr[W-1:1]};
            default: sr <= sr;
        endcase
    assign sout = (mode == 2'b10) ? sr[0] : sr[W-1];

    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        int           ab;
        int           rk;
        logic [W-1:0] stream;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] serial_stream(input logic [W-1:0] d, input logic dr);
        logic [W-1:0] s;
        for (int k = 0; k < W; k++) s[W-1-k] = dr ? d[k] : d[W-1-k];
        return s;
    endfunction

    // Called at a negedge while the DUT is IDLE; returns at a negedge in IDLE.
    // ab: -1 none, -2 abort in LOAD, 0..W-1 abort in shift k, W abort in DONE.
    // rk: shift cycle in which rst is pulsed between edges, -1 for none.
    task automatic run_word(input logic [W-1:0] d, input logic dr, input logic [W-1:0] stream,
                            input int ab, input int rk);
        chk("idle_ready", 32'(tx_ready), 1);
        chk("idle_mode", 32'(mode), 0);
        chk("idle_busy", 32'(busy), 0);
        tx_data  = d;
        tx_dir   = dr;
        tx_valid = 1'b1;
        abort    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("load_mode", 32'(mode), 3);
        chk("load_pin", 32'(pin), 32'(d));
        chk("load_ready", 32'(tx_ready), 0);
        chk("load_busy", 32'(busy), 1);
        chk("load_vld", 32'(sout_vld), 0);
`ifdef SHIFTREG_TX_PARITY_EN
        chk("load_parity", 32'(parity), 32'(^d));
`endif
        tx_data  = W'($urandom);
        tx_dir   = 1'($urandom);
        tx_valid = 1'($urandom);
        abort    = (ab == -2);
        if (ab == -2) begin
            @(negedge clk);
            chk("abort_load_mode", 32'(mode), 0);
            chk("abort_load_busy", 32'(busy), 0);
            chk("abort_load_ready", 32'(tx_ready), 1);
            abort    = 1'b0;
            tx_valid = 1'b0;
            return;
        end
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            abort = (ab == k);
            chk("shift_mode", 32'(mode), dr ? 2 : 1);
            chk("shift_vld", 32'(sout_vld), 1);
            chk("shift_sin", 32'(sin), 0);
            chk("shift_cnt", 32'(bit_cnt), 32'(k));
            chk("shift_sout", 32'(sout), 32'(stream[W-1-k]));
            chk("shift_done", 32'(done), 0);
`ifdef SHIFTREG_TX_PARITY_EN
            chk("shift_par_vld", 32'(par_vld), 0);
`endif
            if (rk == k) begin
                tx_valid = 1'b0;
                abort    = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_mode", 32'(mode), 0);
                chk("rst_pin", 32'(pin), 0);
                chk("rst_sin", 32'(sin), 0);
                chk("rst_vld", 32'(sout_vld), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_cnt", 32'(bit_cnt), 0);
                chk("rst_ready", 32'(tx_ready), 1);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_after_done", 32'(done), 0);
                return;
            end
            if (ab == k) begin
                @(negedge clk);
                chk("abort_mode", 32'(mode), 0);
                chk("abort_vld", 32'(sout_vld), 0);
                chk("abort_cnt", 32'(bit_cnt), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_ready", 32'(tx_ready), 1);
                abort    = 1'b0;
                tx_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        chk("done_cnt", 32'(bit_cnt), W);
        chk("done_mode", 32'(mode), 0);
        chk("done_vld", 32'(sout_vld), 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_ready", 32'(tx_ready), 0);
        chk("done_sreg", 32'(sr), 0);
`ifdef SHIFTREG_TX_PARITY_EN
        chk("done_par_vld", 32'(par_vld), 1);
        chk("done_parity", 32'(parity), 32'(^d));
`endif
        abort    = (ab == W);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_ready", 32'(tx_ready), 1);
        chk("post_cnt", 32'(bit_cnt), 0);
        abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   acc[$];
        int   lowcnt;
        tbl = '{
            '{8'hC1, 1'b0, -1, -1, 8'hC1},
            '{8'hC1, 1'b1, -1, -1, 8'h83},
            '{8'hFF, 1'b0,  3, -1, 8'hFF},
            '{8'h12, 1'b1, -1, -1, 8'h48},
            '{8'hFF, 1'b1, -1,  5, 8'hFF},
            '{8'h81, 1'b0, -1, -1, 8'h81},
            '{8'h0F, 1'b1, -2, -1, 8'hF0},
            '{8'h5A, 1'b0,  8, -1, 8'h5A},
            '{8'h07, 1'b1, -1, -1, 8'hE0},
            '{8'h03, 1'b0, -1, -1, 8'h03}
        };
        rst = 1'b1; tx_data = '0; tx_valid = 1'b0; tx_dir = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mode", 32'(mode), 0);
        chk("reset_ready", 32'(tx_ready), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cnt", 32'(bit_cnt), 0);
        chk("reset_pin", 32'(pin), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_word(tbl[i].data, tbl[i].dir, tbl[i].stream, tbl[i].ab, tbl[i].rk);

        // tx_valid held high across two words: accepts exactly W+3 cycles apart
        acc.delete();
        lowcnt   = 0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tx_dir   = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (acc.size() == 1) tx_data = 8'h3C;
            if (acc.size() == 2) tx_valid = 1'b0;
            if (c == 1) chk("thru_pin_first", 32'(pin), 32'h A5);
            if (c == 12) begin
                chk("thru_pin_second", 32'(pin), 32'h3C);
                chk("thru_mode_second", 32'(mode), 3);
            end
            if (tx_ready && tx_valid) acc.push_back(c);
            else if (acc.size() == 1 && !tx_ready) lowcnt++;
            @(negedge clk);
        end
        chk("thru_accepts", 32'(acc.size()), 2);
        if (acc.size() == 2) chk("thru_gap", 32'(acc[1] - acc[0]), W + 3);
        chk("thru_ready_low", 32'(lowcnt), W + 2);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] d;
            logic         dr;
            int           r, ab;
            d  = W'($urandom);
            dr = 1'($urandom);
            r  = $urandom_range(0, 9);
            ab = (r < 6) ? -1 : (r == 6) ? -2 : $urandom_range(0, W);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_word(d, dr, serial_stream(d, dr), ab, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
